// File: rtl/serial_subtract_sequencer_if.sv
// Producer/consumer handshake bundle for the bit-serial subtractor: operands in, difference/borrow out.
// The master modport is the requester side; slave is the subtractor itself.
interface serial_subtract_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Clear_In;
    logic                  In_Valid_In;
    logic                  In_Ready_Out;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Out_Valid_Out;
    logic                  Out_Ready_In;
    logic [DATA_WIDTH-1:0] Difference_Out;
    logic                  Borrow_Out;

    modport master (
        output Clear_In,
        output In_Valid_In,
        input  In_Ready_Out,
        output Data_A_In,
        output Data_B_In,
        input  Out_Valid_Out,
        output Out_Ready_In,
        input  Difference_Out,
        input  Borrow_Out
    );

    modport slave (
        input  Clear_In,
        input  In_Valid_In,
        output In_Ready_Out,
        input  Data_A_In,
        input  Data_B_In,
        output Out_Valid_Out,
        input  Out_Ready_In,
        output Difference_Out,
        output Borrow_Out
    );
endinterface

// File: rtl/serial_subtract_sequencer.sv
// Bit-serial A-B, LSB first through one 1-bit subtract cell; DATA_WIDTH cycles accept-to-valid.
// Busy (In_Ready_Out=0) from accept until the result is taken; a stalled result is held stable.
module serial_subtract_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                            Clk_In,
    input  logic                            Rst_n_In,
    serial_subtract_sequencer_if.slave      bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 64) begin : g_bad_width
        $error("serial_subtract_sequencer: DATA_WIDTH must be 2..64");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic [DATA_WIDTH-1:0] a_sh_q,     a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q,     b_sh_d;
    logic [DATA_WIDTH-1:0] res_sh_q,   res_sh_d;
    logic [DATA_WIDTH-1:0] diff_out_q, diff_out_d;
    logic                  borrow_q,   borrow_d;
    logic                  brw_out_q,  brw_out_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    // Subtract cell: two chained half-subtractors, borrow-in from the flop.
    logic cell_a, cell_b, d1, b1, cell_diff, b2, cell_bout;

    assign cell_a    = a_sh_q[0];
    assign cell_b    = b_sh_q[0];
    assign d1        = cell_a ^ cell_b;
    assign b1        = ~cell_a & cell_b;
    assign cell_diff = d1 ^ borrow_q;
    assign b2        = ~d1 & borrow_q;
    assign cell_bout = b1 | b2;

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_sh_d   = res_sh_q;
        diff_out_d = diff_out_q;
        borrow_d   = borrow_q;
        brw_out_d  = brw_out_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.In_Valid_In) begin
                    a_sh_d   = bus.Data_A_In;
                    b_sh_d   = bus.Data_B_In;
                    res_sh_d = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {cell_diff, res_sh_q[DATA_WIDTH-1:1]};
                borrow_d = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    diff_out_d = {cell_diff, res_sh_q[DATA_WIDTH-1:1]};
                    brw_out_d  = cell_bout;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.Out_Ready_In) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over every handshake and must not publish a half-finished result.
        if (bus.Clear_In) begin
            state_d    = ST_IDLE;
            diff_out_d = diff_out_q;
            brw_out_d  = brw_out_q;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Rst_n_In) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            diff_out_q <= '0;
            borrow_q   <= 1'b0;
            brw_out_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_sh_q   <= res_sh_d;
            diff_out_q <= diff_out_d;
            borrow_q   <= borrow_d;
            brw_out_q  <= brw_out_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.In_Ready_Out   = (state_q == ST_IDLE);
    assign bus.Out_Valid_Out  = (state_q == ST_DONE);
    assign bus.Difference_Out = diff_out_q;
    assign bus.Borrow_Out     = brw_out_q;
endmodule
